// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, default operand width, default counter width.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int DIV_WIDTH_DEFAULT = 32;
    // Counter must reach WIDTH itself (the post-iteration capture cycle).
    localparam int DIV_CNT_W         = $clog2(DIV_WIDTH_DEFAULT + 1);

endpackage

// File: rtl/iter_divider_if.sv
// Request/result bundle between datapath control and the iterative divider.
// Latency: n/a (wiring only).
// Backpressure: master holds start until it sees ready; no queueing in the slave.
// Signals: start, dividend, divisor, is_signed (only with DIV_SIGNED_EN) from master;
//          ready, done, quotient, remainder, div_by_zero from slave.
interface iter_divider_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) ();

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
`ifdef DIV_SIGNED_EN
    logic             is_signed;
`endif
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start,
        output dividend,
        output divisor,
`ifdef DIV_SIGNED_EN
        output is_signed,
`endif
        input  ready,
        input  done,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
`ifdef DIV_SIGNED_EN
        input  is_signed,
`endif
        output ready,
        output done,
        output quotient,
        output remainder,
        output div_by_zero
    );

endinterface

// File: rtl/div_trial_sub.sv
// Combinational trial subtractor for one restoring-division step.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: part_rem (WIDTH+1, already shifted), divisor (WIDTH) in; diff (low WIDTH bits), non_neg out.
module div_trial_sub
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH:0]   part_rem,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] diff,
    output logic             non_neg
);

    logic [WIDTH:0] full_diff;

    assign full_diff = part_rem - {1'b0, divisor};
    // When the difference is kept it is below the divisor, so the top bit is
    // always zero and only the low WIDTH bits need to leave this block.
    assign diff      = full_diff[WIDTH-1:0];
    assign non_neg   = ~full_diff[WIDTH];

endmodule

// File: rtl/iter_divider.sv
// Restoring shift/subtract divider, one quotient bit per clock (DIV/DIVU: quotient->LO, remainder->HI).
// Latency: fixed WIDTH+2 cycles from the start cycle to the one-cycle done pulse.
// Backpressure: ready is high only in IDLE; start while busy is dropped, no queueing.
// Ports: clk, rst_n (async active-low), bus (iter_divider_if.slave).
// Optional: define DIV_SIGNED_EN to add bus.is_signed and MIPS DIV signed semantics.
module iter_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    iter_divider_if.slave bus
);

    localparam int CNT_W = (WIDTH == DIV_WIDTH_DEFAULT) ? DIV_CNT_W : $clog2(WIDTH + 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] quo_q;      // dividend shifts out the top, quotient bits shift in
    logic [WIDTH-1:0] rem_q;      // partial remainder; always < divisor (or the dividend prefix when divisor=0)
    logic [WIDTH-1:0] dvs_q;
    logic             dz_q;
    logic [WIDTH-1:0] quo_out_q;
    logic [WIDTH-1:0] rem_out_q;
    logic             dz_out_q;

    logic             accept;
    logic             last;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial_diff;
    logic             trial_ok;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;

`ifdef DIV_SIGNED_EN
    logic             neg_quo_q;
    logic             neg_rem_q;

    // Magnitudes of the operands; the most-negative value maps onto itself,
    // which is the correct unsigned magnitude 2^(WIDTH-1).
    assign dvd_mag = (bus.is_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
    assign dvs_mag = (bus.is_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
`else
    assign dvd_mag = bus.dividend;
    assign dvs_mag = bus.divisor;
`endif

    // The register-top bit of the shifted remainder is implicit: rem_q never
    // holds a value that needs WIDTH+1 bits once the trial decision is made.
    assign shifted = {rem_q, quo_q[WIDTH-1]};

    div_trial_sub #(
        .WIDTH (WIDTH)
    ) u_trial (
        .part_rem (shifted),
        .divisor  (dvs_q),
        .diff     (trial_diff),
        .non_neg  (trial_ok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Count reaches WIDTH after the final iteration; this extra
                // RUN cycle only captures the results.
                if (cnt_q == CNT_W'(WIDTH)) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            dz_q      <= 1'b0;
            quo_out_q <= '0;
            rem_out_q <= '0;
            dz_out_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else if (accept) begin
            cnt_q <= '0;
            quo_q <= dvd_mag;
            rem_q <= '0;
            dvs_q <= dvs_mag;
            dz_q  <= (bus.divisor == '0);
`ifdef DIV_SIGNED_EN
            // On divide-by-zero the quotient must stay all ones, so only the
            // remainder is re-signed (which restores the original dividend).
            neg_quo_q <= bus.is_signed && (bus.divisor != '0) &&
                         (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            neg_rem_q <= bus.is_signed && bus.dividend[WIDTH-1];
`endif
        end else if (last) begin
`ifdef DIV_SIGNED_EN
            quo_out_q <= neg_quo_q ? -quo_q : quo_q;
            rem_out_q <= neg_rem_q ? -rem_q : rem_q;
`else
            quo_out_q <= quo_q;
            rem_out_q <= rem_q;
`endif
            dz_out_q  <= dz_q;
        end else if (state_q == RUN) begin
            rem_q <= trial_ok ? trial_diff : shifted[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], trial_ok};
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.ready       = (state_q == IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.quotient    = quo_out_q;
    assign bus.remainder   = rem_out_q;
    assign bus.div_by_zero = dz_out_q;

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider (WIDTH=32) with a queue-based scoreboard.
// Latency: checks done exactly WIDTH+2 cycles after the start cycle.
// Backpressure: exercises start while busy, back-to-back issue and mid-op reset.
// Signed cases are compiled in only when DIV_SIGNED_EN is defined.
module tb_iter_divider;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } res_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    res_t sb[$];

    iter_divider_if #(.WIDTH(W)) bus ();

    iter_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic res_t model(logic [W-1:0] a, logic [W-1:0] b, logic sgn);
        res_t   e;
        longint sa;
        longint sbv;
        if (b == '0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
        end else if (sgn) begin
            sa   = longint'($signed(a));
            sbv  = longint'($signed(b));
            e.q  = W'(sa / sbv);
            e.r  = W'(sa % sbv);
            e.dz = 1'b0;
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Drive a one-cycle start request in the next cycle and record the expectation.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
`ifdef DIV_SIGNED_EN
        bus.is_signed = sgn;
`endif
        sb.push_back(model(a, b, sgn));
    endtask

    // Count cycles from the start cycle until done; inputs are scrambled after accept.
    task automatic wait_done(output int lat, output logic rdy1);
        lat  = -1;
        rdy1 = 1'bx;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 1) begin
                rdy1         = bus.ready;
                bus.start    = 1'b0;
                bus.dividend = $urandom;
                bus.divisor  = $urandom;
`ifdef DIV_SIGNED_EN
                bus.is_signed = 1'($urandom_range(0, 1));
`endif
            end
            if (bus.done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", bus.ready); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", bus.done); end
        checks++; if (bus.quotient !== '0) begin errors++; $display("FAIL reset_quotient got=%h want=0", bus.quotient); end
        checks++; if (bus.remainder !== '0) begin errors++; $display("FAIL reset_remainder got=%h want=0", bus.remainder); end
        checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got=%b want=0", bus.div_by_zero); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Shared body for single-operation scenarios: latency, ready drop, results, clean return to IDLE.
    task automatic test_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        int   lat;
        logic rdy1;
        res_t exp;
        issue(a, b, sgn);
        wait_done(lat, rdy1);
        exp = sb.pop_front();
        checks++; if (lat !== 34) begin errors++; $display("FAIL %s_latency got=%0d want=34", name, lat); end
        checks++; if (rdy1 !== 1'b0) begin errors++; $display("FAIL %s_busy_ready got=%b want=0", name, rdy1); end
        checks++; if (bus.quotient !== exp.q) begin errors++; $display("FAIL %s_quotient got=%h want=%h", name, bus.quotient, exp.q); end
        checks++; if (bus.remainder !== exp.r) begin errors++; $display("FAIL %s_remainder got=%h want=%h", name, bus.remainder, exp.r); end
        checks++; if (bus.div_by_zero !== exp.dz) begin errors++; $display("FAIL %s_dz got=%b want=%b", name, bus.div_by_zero, exp.dz); end
        @(negedge clk);
        checks++; if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin
            errors++; $display("FAIL %s_after_done ready=%b done=%b want ready=1 done=0", name, bus.ready, bus.done);
        end
    endtask

    task automatic test_basic();
        test_op("basic", 32'd100, 32'd7, 1'b0);
        checks++; if (bus.quotient !== 32'd14 || bus.remainder !== 32'd2) begin
            errors++; $display("FAIL basic_const got=%0d/%0d want=14/2", bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_div_zero();
        test_op("divzero", 32'd5, 32'd0, 1'b0);
    endtask

    task automatic test_extremes();
        logic [W-1:0] tab_a [3] = '{32'hFFFF_FFFF, 32'd3,  32'hFFFF_FFFF};
        logic [W-1:0] tab_b [3] = '{32'd1,         32'd10, 32'hFFFF_FFFF};
        for (int i = 0; i < 3; i++) test_op($sformatf("extreme%0d", i), tab_a[i], tab_b[i], 1'b0);
    endtask

    task automatic test_busy();
        int   lat = -1;
        int   extra = 0;
        res_t exp;
        issue(32'd100, 32'd7, 1'b0);
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
            if (k == 5) begin bus.start = 1'b1; bus.dividend = 32'd9; bus.divisor = 32'd3; end
            if (k == 6) bus.start = 1'b0;
            if (bus.done) begin lat = k; break; end
        end
        exp = sb.pop_front();
        checks++; if (lat !== 34) begin errors++; $display("FAIL busy_latency got=%0d want=34", lat); end
        checks++; if (bus.quotient !== exp.q || bus.remainder !== exp.r) begin
            errors++; $display("FAIL busy_result got=%0d/%0d want=%0d/%0d", bus.quotient, bus.remainder, exp.q, exp.r);
        end
        repeat (40) begin @(negedge clk); if (bus.done) extra++; end
        checks++; if (extra !== 0) begin errors++; $display("FAIL busy_ignored extra_done=%0d want=0", extra); end
    endtask

    task automatic test_back_to_back();
        int   lat;
        logic rdy1;
        res_t exp;
        issue(32'd100, 32'd7, 1'b0);
        wait_done(lat, rdy1);
        exp = sb.pop_front();
        checks++; if (bus.quotient !== exp.q) begin errors++; $display("FAIL b2b_first got=%h want=%h", bus.quotient, exp.q); end
        issue(32'd9, 32'd3, 1'b0);
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b want=1", bus.ready); end
        wait_done(lat, rdy1);
        exp = sb.pop_front();
        checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_latency got=%0d want=34", lat); end
        checks++; if (bus.quotient !== exp.q || bus.remainder !== exp.r) begin
            errors++; $display("FAIL b2b_second got=%0d/%0d want=%0d/%0d", bus.quotient, bus.remainder, exp.q, exp.r);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        int seen = 0;
        issue(32'd1000, 32'd3, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb.delete();
        checks++; if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin
            errors++; $display("FAIL midrst_ctrl ready=%b done=%b want ready=1 done=0", bus.ready, bus.done);
        end
        checks++; if (bus.quotient !== '0 || bus.remainder !== '0 || bus.div_by_zero !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs got=%h/%h/%b want=0/0/0", bus.quotient, bus.remainder, bus.div_by_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin @(negedge clk); if (bus.done) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_done got=%0d want=0", seen); end
        test_op("after_rst", 32'd20, 32'd6, 1'b0);
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = (i % 2 == 0) ? W'($urandom_range(1, 300)) : W'($urandom);
            test_op($sformatf("rand%0d", i), a, b, 1'b0);
        end
    endtask

`ifdef DIV_SIGNED_EN
    task automatic test_signed();
        test_op("s_neg7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
        checks++; if (bus.quotient !== 32'hFFFF_FFFD || bus.remainder !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL s_neg7_2_const got=%h/%h want=fffffffd/ffffffff", bus.quotient, bus.remainder);
        end
        test_op("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        test_op("u_neg7_2", 32'hFFFF_FFF9, 32'd2, 1'b0);
        checks++; if (bus.quotient !== 32'h7FFF_FFFC || bus.remainder !== 32'd1) begin
            errors++; $display("FAIL u_neg7_2_const got=%h/%h want=7ffffffc/1", bus.quotient, bus.remainder);
        end
        test_op("s_divzero", 32'hFFFF_FFFB, 32'd0, 1'b1);
        test_op("s_pos_neg", 32'd100, 32'hFFFF_FFF9, 1'b1);
    endtask
`endif

    initial begin
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
`ifdef DIV_SIGNED_EN
        bus.is_signed = 1'b0;
`endif
        test_reset();
        test_basic();
        test_div_zero();
        test_extremes();
        test_busy();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
`ifdef DIV_SIGNED_EN
        test_signed();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
